// File: rtl/rfg_axis_framing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rfg_axis_framing_pkg
// Brief    : Shared constants and FSM state encoding for the readout
//            framing / deframing pair.
// Revision : 1.0 - initial release
// ============================================================================
package rfg_axis_framing_pkg;

  // Link fill byte; also terminates a frame when seen inside one.
  localparam logic [7:0] c_IDLE_BYTE = 8'hBC;

  // Deframer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rfg_axis_readout_deframing_if.sv
`default_nettype none
// ============================================================================
// Module   : rfg_axis_readout_deframing_if
// Brief    : Link-side byte stream plus regenerated AXI-Stream frame bus.
//            slave  = deframer view, master = link source / frame sink view.
// Revision : 1.0 - initial release
// ============================================================================
interface rfg_axis_readout_deframing_if;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic [7:0] m_axis_tid;
  logic       m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
  );
endinterface
`default_nettype wire

// File: rtl/rfg_axis_readout_deframing.sv
`default_nettype none
// ============================================================================
// Module   : rfg_axis_readout_deframing
// Brief    : Strips IDLE fill and channel delimiter from the link byte stream
//            and regenerates AXI-Stream frames (tid/tdata/tlast). One data
//            byte is held back so the terminator can mark tlast.
// Revision : 1.0 - initial release
// ============================================================================
module rfg_axis_readout_deframing
  import rfg_axis_framing_pkg::*;
#(
  parameter int         MTU_SIZE  = 16,
  parameter logic [7:0] IDLE_BYTE = c_IDLE_BYTE
) (
  input  wire logic                           clk,
  input  wire logic                           resn,
  rfg_axis_readout_deframing_if.slave         axis,
  output logic                                err_overflow,
  output logic                                err_empty
);

  localparam int              c_CNT_W   = $clog2(MTU_SIZE + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MTU_SIZE);

  state_t               r_state;
  state_t               w_next_state;
  logic [7:0]           r_tid;
  logic [7:0]           r_hold;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [7:0]           r_m_tdata;
  logic                 r_m_tvalid;
  logic                 r_m_tlast;
  logic [7:0]           r_m_tid;
  logic                 r_err_ovf;
  logic                 r_err_empty;

  logic                 w_out_free;
  logic                 w_tready;
  logic                 w_acc;
  logic                 w_is_idle;
  logic                 w_push;
  logic                 w_push_last;
  logic                 w_hold_load;
  logic                 w_cnt_first;
  logic                 w_cnt_inc;
  logic                 w_tid_load;
  logic                 w_err_empty;
  logic                 w_err_ovf;

  assign w_out_free = !r_m_tvalid || axis.m_axis_tready;
  assign w_is_idle  = (axis.s_axis_tdata == IDLE_BYTE);

  // Next-state, link ready and datapath strobes from the current state.
  always_comb begin
    w_next_state = r_state;
    w_tready     = 1'b1;
    w_push       = 1'b0;
    w_push_last  = 1'b0;
    w_hold_load  = 1'b0;
    w_cnt_first  = 1'b0;
    w_cnt_inc    = 1'b0;
    w_tid_load   = 1'b0;
    w_err_empty  = 1'b0;
    w_err_ovf    = 1'b0;
    if (r_state == ST_DATA) begin
      w_tready = w_out_free;
    end
    w_acc = axis.s_axis_tvalid && w_tready;
    if (w_acc) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_is_idle) begin
            w_tid_load   = 1'b1;
            w_next_state = ST_HDR;
          end
        end
        ST_HDR: begin
          if (w_is_idle) begin
            w_err_empty  = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_hold_load  = 1'b1;
            w_cnt_first  = 1'b1;
            w_next_state = ST_DATA;
          end
        end
        ST_DATA: begin
          w_push = 1'b1;
          if (w_is_idle) begin
            w_push_last  = 1'b1;
            w_next_state = ST_IDLE;
          end else if (r_cnt < c_CNT_MAX) begin
            w_hold_load = 1'b1;
            w_cnt_inc   = 1'b1;
          end else begin
            w_push_last  = 1'b1;
            w_err_ovf    = 1'b1;
            w_next_state = ST_DROP;
          end
        end
        ST_DROP: begin
          if (w_is_idle) begin
            w_next_state = ST_IDLE;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Channel capture, one-byte lookahead holding register and frame length.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      r_tid  <= 8'h00;
      r_hold <= 8'h00;
      r_cnt  <= '0;
    end else begin
      if (w_tid_load) begin
        r_tid <= axis.s_axis_tdata;
      end
      if (w_hold_load) begin
        r_hold <= axis.s_axis_tdata;
      end
      if (w_cnt_first) begin
        r_cnt <= c_CNT_ONE;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
    end
  end

  // Output register: load on push, otherwise drop valid once consumed.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      r_m_tdata  <= 8'h00;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tid    <= 8'h00;
    end else if (w_push) begin
      r_m_tdata  <= r_hold;
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= w_push_last;
      r_m_tid    <= r_tid;
    end else if (axis.m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  // Single-cycle error pulses.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      r_err_ovf   <= 1'b0;
      r_err_empty <= 1'b0;
    end else begin
      r_err_ovf   <= w_err_ovf;
      r_err_empty <= w_err_empty;
    end
  end

  assign axis.s_axis_tready = w_tready;
  assign axis.m_axis_tdata  = r_m_tdata;
  assign axis.m_axis_tvalid = r_m_tvalid;
  assign axis.m_axis_tlast  = r_m_tlast;
  assign axis.m_axis_tid    = r_m_tid;
  assign err_overflow       = r_err_ovf;
  assign err_empty          = r_err_empty;

endmodule
`default_nettype wire

// File: tb/tb_rfg_axis_readout_deframing.sv
`default_nettype none
// ============================================================================
// Module   : tb_rfg_axis_readout_deframing
// Brief    : Directed bench for the readout deframer (MTU_SIZE = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rfg_axis_readout_deframing;

  logic clk;
  logic resn;
  logic err_overflow;
  logic err_empty;

  rfg_axis_readout_deframing_if bus();

  rfg_axis_readout_deframing #(
    .MTU_SIZE  (4),
    .IDLE_BYTE (8'hBC)
  ) dut (
    .clk          (clk),
    .resn         (resn),
    .axis         (bus),
    .err_overflow (err_overflow),
    .err_empty    (err_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observed output beats and error pulses.
  logic [7:0] q_data[$];
  logic [7:0] q_tid[$];
  logic       q_last[$];
  int         n_empty = 0;
  int         n_ovf   = 0;

  always @(negedge clk) begin
    if (resn) begin
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        q_data.push_back(bus.m_axis_tdata);
        q_tid.push_back(bus.m_axis_tid);
        q_last.push_back(bus.m_axis_tlast);
      end
      if (err_empty)    n_empty++;
      if (err_overflow) n_ovf++;
    end
  end

  typedef struct {
    logic [7:0][7:0] din;
    int              n_in;
    logic [3:0][7:0] dout;
    logic [3:0][7:0] dtid;
    logic [3:0]      dlast;
    int              n_out;
    int              n_emp;
    int              n_ov;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present one link byte and hold it until accepted (bounded).
  task automatic drive_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    bus.s_axis_tdata  = b;
    bus.s_axis_tvalid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.s_axis_tready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) chk($sformatf("accept timeout byte %0h", b), 0, 1);
  endtask

  task automatic flush();
    bus.s_axis_tvalid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_beats(input string tag, input int base, input int n,
                             input logic [3:0][7:0] dout, input logic [3:0][7:0] dtid,
                             input logic [3:0] dlast);
    chk({tag, " beat count"}, q_data.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < q_data.size()) begin
        chk($sformatf("%s beat%0d data", tag, i), q_data[base+i], dout[n-1-i]);
        chk($sformatf("%s beat%0d tid",  tag, i), q_tid[base+i],  dtid[n-1-i]);
        chk($sformatf("%s beat%0d last", tag, i), q_last[base+i], dlast[n-1-i]);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " m_tvalid"}, bus.m_axis_tvalid, 0);
    chk({tag, " m_tlast"},  bus.m_axis_tlast,  0);
    chk({tag, " m_tdata"},  bus.m_axis_tdata,  0);
    chk({tag, " m_tid"},    bus.m_axis_tid,    0);
    chk({tag, " s_tready"}, bus.s_axis_tready, 1);
    chk({tag, " err_empty"}, err_empty,        0);
    chk({tag, " err_ovf"},  err_overflow,      0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, be, bo;

    // Bytes listed in link order; the first entry lands in the top lane.
    vecs[0] = '{64'({8'hBC, 8'hBC, 8'h05, 8'h11, 8'h22, 8'h33, 8'hBC}), 7,
                32'({8'h11, 8'h22, 8'h33}), 32'({8'h05, 8'h05, 8'h05}), 4'(3'b001), 3, 0, 0};
    vecs[1] = '{64'({8'h07, 8'hBC}), 2, 32'h0, 32'h0, 4'h0, 0, 1, 0};
    vecs[2] = '{{8'h02, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hBC}, 8,
                {8'hA1, 8'hA2, 8'hA3, 8'hA4}, {8'h02, 8'h02, 8'h02, 8'h02}, 4'b0001, 4, 0, 1};
    vecs[3] = '{64'({8'h03, 8'hB1, 8'hBC}), 3, 32'({8'hB1}), 32'({8'h03}), 4'(1'b1), 1, 0, 0};
    vecs[4] = '{64'({8'h01, 8'hAA, 8'hBC, 8'h02, 8'hBB, 8'hBC}), 6,
                32'({8'hAA, 8'hBB}), 32'({8'h01, 8'h02}), 4'(2'b11), 2, 0, 0};
    vecs[5] = '{64'({8'h04, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hBC}), 6,
                {8'hC1, 8'hC2, 8'hC3, 8'hC4}, {8'h04, 8'h04, 8'h04, 8'h04}, 4'b0001, 4, 0, 0};

    resn              = 1'b0;
    bus.s_axis_tdata  = 8'h00;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    resn = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven frames with the sink always ready.
    for (int v = 0; v < 6; v++) begin
      base = q_data.size();
      be   = n_empty;
      bo   = n_ovf;
      for (int i = 0; i < vecs[v].n_in; i++) begin
        drive_byte(vecs[v].din[vecs[v].n_in-1-i]);
      end
      flush();
      check_beats($sformatf("v%0d", v), base, vecs[v].n_out,
                  vecs[v].dout, vecs[v].dtid, vecs[v].dlast);
      chk($sformatf("v%0d err_empty pulses", v), n_empty - be, vecs[v].n_emp);
      chk($sformatf("v%0d err_ovf pulses", v),   n_ovf - bo,   vecs[v].n_ov);
    end

    // Sink stall for 3 cycles right after the first byte is pushed.
    base = q_data.size();
    fork
      begin
        drive_byte(8'hBC); drive_byte(8'hBC); drive_byte(8'h05);
        drive_byte(8'h11); drive_byte(8'h22); drive_byte(8'h33);
        drive_byte(8'hBC);
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
          @(posedge clk);
          #1;
          if (bus.m_axis_tvalid) seen = 1'b1;
        end
        if (!seen) chk("stall wait for push", 0, 1);
        bus.m_axis_tready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(posedge clk);
          #1;
          chk($sformatf("stall c%0d m_tdata", c),  bus.m_axis_tdata,  8'h11);
          chk($sformatf("stall c%0d m_tvalid", c), bus.m_axis_tvalid, 1);
          chk($sformatf("stall c%0d s_tready", c), bus.s_axis_tready, 0);
        end
        bus.m_axis_tready = 1'b1;
      end
    join
    flush();
    check_beats("stall", base, 3, 32'({8'h11, 8'h22, 8'h33}),
                32'({8'h05, 8'h05, 8'h05}), 4'(3'b001));

    // Reset in the middle of a frame.
    base = q_data.size();
    drive_byte(8'h05); drive_byte(8'h11); drive_byte(8'h22);
    bus.s_axis_tvalid = 1'b0;
    resn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midreset held");
    resn = 1'b1;
    @(posedge clk);
    #1;
    drive_byte(8'h06); drive_byte(8'h33); drive_byte(8'hBC);
    flush();
    check_beats("after reset", base, 1, 32'({8'h33}), 32'({8'h06}), 4'(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
